// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter for a single-port, fixed-latency data memory
module mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [XLEN-1:0] ifu_addr,
  output logic            ifu_resp_valid,
  output logic [XLEN-1:0] ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_wen,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_resp_valid,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  state_t state;
  logic last_grant, owner, wen, pick_lsu;
  logic [3:0] cnt;
  logic [XLEN-1:0] addr, wdata;
  // last_grant/owner: 0 = IFU, 1 = LSU; a tie goes to whoever was not served last
  always_comb pick_lsu = lsu_req_valid && (!ifu_req_valid || !last_grant);
  assign ifu_req_ready = state == IDLE && ifu_req_valid && !pick_lsu;
  assign lsu_req_ready = state == IDLE && pick_lsu;
  assign mem_read = state == ISSUE && !wen;
  assign mem_write = state == ISSUE && wen;
  assign mem_addr = addr;
  assign mem_wdata = wdata;
  assign busy = state != IDLE;
  assign ifu_resp_valid = state == RESP && !owner;
  assign lsu_resp_valid = state == RESP && owner;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b0;
      owner <= 1'b0;
      wen <= 1'b0;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (ifu_req_ready || lsu_req_ready) begin
          state <= ISSUE;
          owner <= pick_lsu;
          last_grant <= pick_lsu;
          addr <= (pick_lsu ? lsu_addr : ifu_addr) & WORD_MASK;
          wdata <= pick_lsu ? lsu_wdata : '0;
          wen <= pick_lsu && lsu_wen;
        end
        ISSUE: begin
          state <= wen ? RESP : WAIT;
          cnt <= wen ? 4'd0 : 4'd1;
        end
        WAIT: if (cnt == LAT) begin
          state <= RESP;
          cnt <= '0;
          if (owner) lsu_rdata <= mem_rdata;
          else ifu_rdata <= mem_rdata;
        end else cnt <= cnt + 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (LATENCY=1 and LATENCY=3 instances)
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic mem_read, mem_write, busy;
  logic [31:0] ifu_addr, ifu_rdata, lsu_addr, lsu_wdata, lsu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic v3, ready3, iready3, iresp3, resp3, read3, write3, busy3;
  logic [31:0] irdata3, rdata3, maddr3, mwdata3, mem_rdata3;
  int tests = 0, fails = 0;
  typedef struct {logic lsu; logic wen; logic [31:0] data;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] model_ifu = '0, model_lsu = '0, wa = '0, wd = '0;
  logic [2:0] pv = '0;

  mem_arbiter #(.LATENCY(1), .XLEN(32)) u_dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_arbiter #(.LATENCY(3), .XLEN(32)) u_dut3 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(1'b0), .ifu_req_ready(iready3), .ifu_addr(32'h0),
    .ifu_resp_valid(iresp3), .ifu_rdata(irdata3),
    .lsu_req_valid(v3), .lsu_req_ready(ready3), .lsu_wen(1'b0),
    .lsu_addr(32'h40), .lsu_wdata(32'h0), .lsu_resp_valid(resp3), .lsu_rdata(rdata3),
    .mem_read(read3), .mem_write(write3), .mem_addr(maddr3), .mem_wdata(mwdata3),
    .mem_rdata(mem_rdata3), .busy(busy3));

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h80000000 ? 32'h00000413 : a == 32'h80000008 ? 32'hCAFE0008 : a ^ 32'h5A5A5A5A;
  endfunction

  // memory models: registered read data for LATENCY=1, a 3-stage pipe with garbage elsewhere for LATENCY=3
  always @(posedge clk) begin
    if (mem_write) begin wa <= mem_addr; wd <= mem_wdata; end
    mem_rdata <= mem_read ? (mem_addr == wa ? wd : rom(mem_addr)) : 32'hBAD0BAD0;
    pv <= {pv[1:0], read3};
  end
  assign mem_rdata3 = pv[2] ? 32'h12345678 : 32'hBADC0DE0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick;
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_ifu = '0;
      model_lsu = '0;
    end else begin
      chk("strobe_excl", {31'b0, mem_read && mem_write}, 0);
      chk("ready_excl", {31'b0, ifu_req_ready && lsu_req_ready}, 0);
      if (ifu_resp_valid || lsu_resp_valid) begin
        chk("resp_excl", {31'b0, ifu_resp_valid && lsu_resp_valid}, 0);
        if (q.size() == 0) chk("resp_unexpected", {30'b0, ifu_resp_valid, lsu_resp_valid}, 0);
        else begin
          e = q.pop_front();
          chk("resp_owner", {31'b0, lsu_resp_valid}, {31'b0, e.lsu});
          if (e.lsu) begin
            if (!e.wen) model_lsu = e.data;
            chk("lsu_rdata", lsu_rdata, model_lsu);
            chk("ifu_rdata_kept", ifu_rdata, model_ifu);
          end else begin
            model_ifu = e.data;
            chk("ifu_rdata", ifu_rdata, model_ifu);
            chk("lsu_rdata_kept", lsu_rdata, model_lsu);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    ifu_req_valid = 0; ifu_addr = '0; lsu_req_valid = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; v3 = 0;
    tick; tick;
    rst = 0;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ifu_rdata", ifu_rdata, 0);
    chk("rst_lsu_rdata", lsu_rdata, 0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 0);
    // IFU read, LATENCY=1
    ifu_req_valid = 1; ifu_addr = 32'h80000000;
    #1;
    chk("t1_ifu_ready", {31'b0, ifu_req_ready}, 1);
    chk("t1_lsu_ready", {31'b0, lsu_req_ready}, 0);
    q.push_back('{1'b0, 1'b0, 32'h00000413});
    tick; ifu_req_valid = 0;
    chk("t1_c1_read", {31'b0, mem_read}, 1);
    chk("t1_c1_write", {31'b0, mem_write}, 0);
    chk("t1_c1_addr", mem_addr, 32'h80000000);
    chk("t1_c1_busy", {31'b0, busy}, 1);
    tick;
    chk("t1_c2_read", {31'b0, mem_read}, 0);
    chk("t1_c2_resp", {31'b0, ifu_resp_valid}, 0);
    tick;
    chk("t1_c3_resp", {31'b0, ifu_resp_valid}, 1);
    chk("t1_c3_rdata", ifu_rdata, 32'h00000413);
    chk("t1_c3_lsu_rdata", lsu_rdata, 0);
    tick;
    chk("t1_c4_resp", {31'b0, ifu_resp_valid}, 0);
    chk("t1_c4_busy", {31'b0, busy}, 0);
    // LSU write with unaligned address
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h80001003; lsu_wdata = 32'hDEADBEEF;
    #1;
    chk("t2_lsu_ready", {31'b0, lsu_req_ready}, 1);
    q.push_back('{1'b1, 1'b1, 32'h0});
    tick; lsu_req_valid = 0;
    chk("t2_c1_write", {31'b0, mem_write}, 1);
    chk("t2_c1_read", {31'b0, mem_read}, 0);
    chk("t2_c1_addr", mem_addr, 32'h80001000);
    chk("t2_c1_wdata", mem_wdata, 32'hDEADBEEF);
    tick;
    chk("t2_c2_resp", {31'b0, lsu_resp_valid}, 1);
    chk("t2_c2_strobes", {30'b0, mem_read, mem_write}, 0);
    chk("t2_c2_rdata", lsu_rdata, 0);
    tick;
    // both valid from reset: LSU, IFU, LSU, IFU
    rst = 1;
    ifu_req_valid = 1; ifu_addr = 32'h80000000;
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h80001000;
    tick; rst = 0;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
        if (ifu_req_ready || lsu_req_ready) begin
          found = 1;
          chk("t3_grant_order", {31'b0, lsu_req_ready}, {31'b0, g % 2 == 0});
          q.push_back('{lsu_req_ready, 1'b0, lsu_req_ready ? 32'hDEADBEEF : 32'h00000413});
        end
        tick;
      end
      chk("t3_grant_seen", {31'b0, found}, 1);
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    drain;
    // LATENCY=3 LSU read
    v3 = 1;
    #1;
    chk("t4_ready", {31'b0, ready3}, 1);
    tick; v3 = 0;
    chk("t4_read", {31'b0, read3}, 1);
    for (int c = 1; c <= 5; c++) begin
      chk("t4_busy", {31'b0, busy3}, 1);
      chk("t4_resp", {31'b0, resp3}, {31'b0, c == 5});
      if (c == 5) chk("t4_rdata", rdata3, 32'h12345678);
      tick;
    end
    chk("t4_idle", {31'b0, busy3}, 0);
    // reset during WAIT drops the LSU read
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h80001000;
    #1;
    chk("t5_lsu_ready", {31'b0, lsu_req_ready}, 1);
    tick; lsu_req_valid = 0;
    tick;
    chk("t5_wait_busy", {31'b0, busy}, 1);
    rst = 1;
    tick; rst = 0;
    chk("t5_busy", {31'b0, busy}, 0);
    chk("t5_strobes", {30'b0, mem_read, mem_write}, 0);
    chk("t5_resp", {30'b0, ifu_resp_valid, lsu_resp_valid}, 0);
    chk("t5_lsu_rdata", lsu_rdata, 0);
    ifu_req_valid = 1; ifu_addr = 32'h80000000; lsu_req_valid = 1;
    #1;
    chk("t5_tie_lsu", {31'b0, lsu_req_ready}, 1);
    chk("t5_tie_ifu", {31'b0, ifu_req_ready}, 0);
    q.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    tick; lsu_req_valid = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (ifu_req_ready) begin
        found = 1;
        q.push_back('{1'b0, 1'b0, 32'h00000413});
      end
      tick;
    end
    ifu_req_valid = 0;
    chk("t5_ifu_seen", {31'b0, found}, 1);
    drain;
    // IFU request waits behind an LSU write; its address changes don't leak
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h80002000; lsu_wdata = 32'h0BADF00D;
    #1;
    chk("t6_lsu_ready", {31'b0, lsu_req_ready}, 1);
    q.push_back('{1'b1, 1'b1, 32'h0});
    tick; lsu_req_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h80000004;
    #1;
    chk("t6_c1_ifu_ready", {31'b0, ifu_req_ready}, 0);
    chk("t6_c1_addr", mem_addr, 32'h80002000);
    chk("t6_c1_write", {31'b0, mem_write}, 1);
    tick; ifu_addr = 32'h80000008;
    #1;
    chk("t6_c2_ifu_ready", {31'b0, ifu_req_ready}, 0);
    chk("t6_c2_addr", mem_addr, 32'h80002000);
    chk("t6_c2_resp", {31'b0, lsu_resp_valid}, 1);
    tick;
    chk("t6_c3_ifu_ready", {31'b0, ifu_req_ready}, 1);
    q.push_back('{1'b0, 1'b0, 32'hCAFE0008});
    tick; ifu_req_valid = 0;
    chk("t6_c4_addr", mem_addr, 32'h80000008);
    chk("t6_c4_read", {31'b0, mem_read}, 1);
    drain;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port DPI-backed data memory (one read or write per access, word-wide, registered read data) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one request at a time through valid/ready handshakes and drives the memory strobes for exactly one cycle.
- Captures read data after a fixed latency and returns a one-cycle response to the winning requester.
- Sits between IFU/LSU and the memory block in the NPC top level.

Parameters:
- LATENCY, 1, cycles from the memory strobe cycle to the cycle in which mem_rdata is valid (legal range 1..15).
- XLEN, 32, address and data width.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous reset, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  XLEN  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid, single cycle
- ifu_rdata  out  XLEN  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  XLEN  LSU address
- lsu_wdata  in  XLEN  LSU write data
- lsu_resp_valid  out  1  LSU read data or write ack, single cycle
- lsu_rdata  out  XLEN  LSU read data
- mem_read  out  1  memory read strobe (MemRead)
- mem_write  out  1  memory write strobe (MemWrite)
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_rdata  in  XLEN  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- FSM states:
  - IDLE -> ISSUE on accept.
  - ISSUE -> WAIT on a read; ISSUE -> RESP on a write.
  - WAIT -> RESP once LATENCY cycles have elapsed.
  - RESP -> IDLE unconditionally.
- Reset:
  - At a posedge with rst=1: state=IDLE, last_grant=IFU, wait counter=0.
  - Latched addr, wdata, wen and owner = 0; ifu_rdata = lsu_rdata = 0.
  - All ready, resp_valid and mem strobes are low from the following cycle.
- Reset mid-operation:
  - The in-flight transaction is dropped; no resp_valid is issued for it.
  - A pending mem strobe is not re-driven.
- Ready:
  - *_req_ready is combinational and is asserted only in IDLE, for the arbitration winner only.
  - A request is accepted when valid && ready.
  - Requesters hold valid, addr, wdata and wen stable until accepted.
- Arbitration (IDLE only), round-robin:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins.
  - last_grant updates to the winner at accept.
  - After reset, a tie goes to the LSU.
- Accept: latch the owner, {addr[XLEN-1:2], 2'b00}, wdata and wen (IFU: wen=0). Low address bits are always cleared; no misalignment trap.
- ISSUE (exactly one cycle):
  - mem_read = ~wen and mem_write = wen; never both high.
  - Strobes are low in every other state.
- mem_addr and mem_wdata continuously drive the latched values (stable across ISSUE/WAIT/RESP).
- WAIT:
  - The counter counts 1..LATENCY.
  - On the cycle the counter equals LATENCY, mem_rdata is registered into the owner's rdata register; the other requester's rdata is unchanged.
- RESP:
  - The owner's *_resp_valid = 1 for exactly one cycle; no back-pressure on responses.
  - The rdata registers hold their value until the next read response to that requester.
  - An LSU write leaves lsu_rdata unchanged.
- Timing, with accept edge = end of cycle 0:
  - Read: ISSUE in cycle 1, WAIT in cycles 2..LATENCY+1, resp_valid in cycle LATENCY+2.
  - Write: resp_valid in cycle 2.
  - Next accept is possible no earlier than the cycle after RESP.
- Requests arriving outside IDLE see ready=0 and wait; valid may drop before accept with no effect.

Test Plan:
- Reset, then IFU read of addr 0x80000000 (mem returns 0x00000413, LATENCY=1): ifu_req_ready=1 in cycle 0; mem_read=1 only in cycle 1; ifu_resp_valid=1 only in cycle 3; ifu_rdata=0x00000413; lsu_rdata stays 0.
- LSU write addr 0x80001003, wdata 0xDEADBEEF: mem_write=1 for one cycle with mem_addr=0x80001000 and mem_wdata=0xDEADBEEF; mem_read=0 throughout; lsu_resp_valid in cycle 2; lsu_rdata unchanged.
- Both valid every cycle from reset: grant order LSU, IFU, LSU, IFU; each resp_valid goes only to the owner; ready is never given to both in one cycle.
- LATENCY=3, LSU read with mem_rdata=0x12345678 valid only 3 cycles after ISSUE (garbage otherwise): lsu_rdata=0x12345678; resp_valid in cycle 5; busy high in cycles 1..5.
- rst=1 pulsed during WAIT: no resp_valid; busy=0 and strobes 0 the next cycle; a following IFU request completes normally; a tie after reset goes to the LSU.
- IFU valid asserted during an LSU transaction: ifu_req_ready stays 0 until IDLE, then accepted; ifu_addr change while not ready does not affect mem_addr of the LSU access.
